// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// A round-robin pointer picks the requester. The operands are held while the
// ALU settles. The result and NZCV flags are then captured and returned on a
// per-requester response channel.
//
// Handshake rule (request and response sides): a transfer happens on a rising
// edge where valid and ready are both high. Once valid is raised it stays high,
// with its payload stable, until that edge.
module alu_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][63:0] req_a,
    input  logic [1:0][63:0] req_b,
    input  logic [1:0][2:0]  req_cntrl,
    input  logic [1:0]       req_setflags,
    output logic [63:0]      alu_a,
    output logic [63:0]      alu_b,
    output logic [2:0]       alu_cntrl,
    input  logic [63:0]      alu_result,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [63:0]      rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [3:0]       flags,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        owner_q, owner_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [2:0]  cntrl_q, cntrl_d;
    logic        sf_q, sf_d;
    logic [63:0] res_q, res_d;
    logic [3:0]  rflags_q, rflags_d;
    logic [3:0]  flags_q, flags_d;

    logic [1:0]  grant;
    logic        gnt_idx;
    logic [3:0]  alu_nzcv;

    assign alu_nzcv = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
    assign gnt_idx  = grant[1];

    // Priority grant: the pointer's requester wins if valid, else the other one.
    always_comb begin
        grant = 2'b00;
        if (reset_n && (state_q == IDLE)) begin
            if (req_valid[ptr_q]) begin
                grant[ptr_q] = 1'b1;
            end else if (req_valid[~ptr_q]) begin
                grant[~ptr_q] = 1'b1;
            end
        end
    end

    // Next-state: accept, count down the settle window, capture, then hand back.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        cntrl_d  = cntrl_q;
        sf_d     = sf_q;
        res_d    = res_q;
        rflags_d = rflags_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    a_d     = req_a[gnt_idx];
                    b_d     = req_b[gnt_idx];
                    cntrl_d = req_cntrl[gnt_idx];
                    sf_d    = req_setflags[gnt_idx];
                    owner_d = gnt_idx;
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    res_d    = alu_result;
                    rflags_d = alu_nzcv;
                    if (sf_q) begin
                        flags_d = alu_nzcv;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Only the owner's rsp_ready matters; no new accept on this edge.
                if (rsp_ready[owner_q]) begin
                    ptr_d   = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            cnt_q    <= 4'd0;
            a_q      <= 64'd0;
            b_q      <= 64'd0;
            cntrl_q  <= 3'd0;
            sf_q     <= 1'b0;
            res_q    <= 64'd0;
            rflags_q <= 4'd0;
            flags_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cntrl_q  <= cntrl_d;
            sf_q     <= sf_d;
            res_q    <= res_d;
            rflags_q <= rflags_d;
            flags_q  <= flags_d;
        end
    end

    // Response valid goes to the owner only while the result is being offered.
    always_comb begin
        rsp_valid = 2'b00;
        if (state_q == RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    assign req_ready  = grant;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_cntrl  = cntrl_q;
    assign rsp_result = res_q;
    assign rsp_flags  = rflags_q;
    assign flags      = flags_q;
    assign busy       = (state_q != IDLE);

endmodule
